// File: rtl/bit_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter_pkg
// Description : Shared constants and helpers for the parametrised bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Bits needed to hold values 0..value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage : bit_counter_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Emits one tick per DIV enabled cycles; restart re-phases it.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import bit_counter_pkg::*;
#(
    parameter int unsigned DIV = 1
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    if (DIV <= 1) begin : g_direct
        // No phase to track: every enabled cycle is a tick.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst, restart};
        assign tick     = en;
    end else begin : g_count
        localparam int c_pw = clog2(int'(DIV));
        localparam logic [c_pw-1:0] c_last = c_pw'(DIV - 1);

        logic [c_pw-1:0] r_phase;
        logic            w_tick;

        assign w_tick = en && (r_phase == c_last);
        assign tick   = w_tick;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_phase <= '0;
            end else if (restart) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= w_tick ? '0 : r_phase + 1'b1;
            end
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/bit_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter_param
// Description : Up/down counter over 0..MAX_VAL with wrap/saturate, clear,
//               clamped load, prescaled enable, terminal count and sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter_param
    import bit_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SAT     = 1'b0,
    parameter int unsigned     DIV     = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_max = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_tick;
    logic             w_restart;

    assign w_restart = clr | load;

    tick_prescaler #(
        .DIV     (DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Priority: clear, then load, then a prescaled step, else hold.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (load) begin
            w_count_nxt = (load_val > c_max) ? c_max : load_val;
        end else if (w_tick) begin
            if (up_dn == DIR_UP) begin
                if (r_count == c_max) begin
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = SAT ? r_count : '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = SAT ? r_count : c_max;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;
    // Independent of en so a chain can feed tc into the next stage's en.
    assign tc    = (up_dn == DIR_UP) ? (r_count == c_max) : (r_count == '0);

endmodule : bit_counter_param
`default_nettype wire
